// File: rtl/sample_packer.sv
// ============================================================================
// Module   : sample_packer
// Purpose  : Capture stage behind the sample-rate divider. It synchronizes
//            16 asynchronous logic inputs. On each enabled tick it packs
//            1/2/4/8 consecutive samples into a 16-bit word. Completed words
//            are offered over a valid/ready handshake. A word that completes
//            while the output register is still occupied is dropped and
//            raises a sticky overflow flag.
// Ports    : clk        - system clock
//            rst_n      - asynchronous reset, active-low
//            enable     - capture enable
//            tick       - one-cycle sample strobe
//            mode       - channel mode (0:16ch x1, 1:8ch x2, 2:4ch x4, 3:2ch x8)
//            channels   - raw asynchronous inputs
//            out_data   - packed sample word
//            out_valid  - out_data holds an unconsumed word
//            out_ready  - consumer accepts the word on out_valid & out_ready
//            overflow   - sticky: at least one completed word was dropped
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_packer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        tick,
  input  logic [1:0]  mode,
  input  logic [15:0] channels,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  logic [SYNC_STAGES-1:0][15:0] sync_ff;
  logic [15:0] sync;
  logic [1:0]  mode_q;
  logic [2:0]  cnt;
  logic [15:0] acc;

  logic [15:0] mask;
  logic [2:0]  last_cnt;
  logic [3:0]  shamt;
  logic [15:0] word;
  logic        fire;
  logic        complete;
  logic        load;

  // Synchronizer chain, free-running regardless of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff[0] <= channels;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_ff[i] <= sync_ff[i-1];
      end
    end
  end

  assign sync = sync_ff[SYNC_STAGES-1];

  // Field mask and final sample index for the latched mode.
  always_comb begin
    mask     = 16'hFFFF;
    last_cnt = 3'd0;
    case (mode_q)
      2'd0: begin mask = 16'hFFFF; last_cnt = 3'd0; end
      2'd1: begin mask = 16'h00FF; last_cnt = 3'd1; end
      2'd2: begin mask = 16'h000F; last_cnt = 3'd3; end
      default: begin mask = 16'h0003; last_cnt = 3'd7; end
    endcase
  end

  // Bit offset of sample k is N*k = (16*k) >> mode_q. The largest offset
  // is 14 (mode 3, k = 7), so four bits are enough.
  assign shamt    = 4'({cnt, 4'b0000} >> mode_q);
  assign word     = acc | ((sync & mask) << shamt);
  assign fire     = tick & enable;
  assign complete = fire & (cnt == last_cnt);
  // The output register can take a new word when empty or draining now.
  assign load     = complete & (~out_valid | out_ready);

  // Mode latch and packing accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 2'd0;
      cnt    <= 3'd0;
      acc    <= 16'h0000;
    end else if (!enable) begin
      mode_q <= mode;
      cnt    <= 3'd0;
      acc    <= 16'h0000;
    end else if (fire) begin
      if (complete) begin
        cnt <= 3'd0;
        acc <= 16'h0000;
      end else begin
        cnt <= cnt + 3'd1;
        acc <= word;
      end
    end
  end

  // Output register and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= 16'h0000;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (!enable) begin
        overflow <= 1'b0;
      end else if (complete && !load) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sample_packer.sv
// ============================================================================
// Module   : tb_sample_packer
// Purpose  : Self-checking bench for sample_packer. It applies directed
//            scenarios and random stimulus. Outputs are compared against a
//            sample-queue reference model after every clock.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sample_packer;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tick = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] channels = 16'h0000;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] pins[$];   // channel value present at each past clock edge
  logic [15:0] smp[$];    // samples collected for the word in progress
  logic [1:0]  m_mode;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ovf;

  sample_packer #(.SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .tick      (tick),
    .mode      (mode),
    .channels  (channels),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pins.delete();
    smp.delete();
    m_mode  = 2'd0;
    m_valid = 1'b0;
    m_data  = 16'h0000;
    m_ovf   = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs in force.
  task automatic model_edge();
    int          n;
    int          s;
    logic [15:0] sync_v;
    logic [15:0] w;
    logic        loaded;
    n      = 16 >> m_mode;
    s      = 1 << m_mode;
    sync_v = (pins.size() >= SS) ? pins[pins.size()-SS] : 16'h0000;
    loaded = 1'b0;
    if (enable) begin
      if (tick) begin
        smp.push_back(16'(sync_v & 16'((32'd1 << n) - 1)));
        if (smp.size() == s) begin
          w = 16'h0000;
          for (int i = 0; i < s; i++) w = w | 16'(smp[i] << (n * i));
          smp.delete();
          if (!m_valid || out_ready) begin
            m_data = w;
            loaded = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end else begin
      smp.delete();
      m_ovf  = 1'b0;
      m_mode = mode;
    end
    if (loaded) m_valid = 1'b1;
    else if (m_valid && out_ready) m_valid = 1'b0;
    pins.push_back(channels);
  endtask

  task automatic step(input logic t, input logic en, input logic rdy,
                      input logic [1:0] m, input logic [15:0] ch);
    tick = t; enable = en; out_ready = rdy; mode = m; channels = ch;
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", 16'(out_valid), 16'(m_valid));
    chk("data", out_data, m_data);
    chk("overflow", 16'(overflow), 16'(m_ovf));
  endtask

  // Hold a value long enough to pass the synchronizer, then tick on it.
  task automatic tick_val(input logic rdy, input logic [1:0] m, input logic [15:0] ch);
    for (int i = 0; i < SS; i++) step(1'b0, 1'b1, rdy, m, ch);
    step(1'b1, 1'b1, rdy, m, ch);
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset_valid", 16'(out_valid), 16'h0000);
    chk("reset_data", out_data, 16'h0000);
    chk("reset_ovf", 16'(overflow), 16'h0000);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode 0, tick every cycle, constant input
    step(1'b0, 1'b0, 1'b1, 2'd0, 16'h1234);
    step(1'b0, 1'b0, 1'b1, 2'd0, 16'h1234);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 2'd0, 16'h1234);
    chk("m0_data", out_data, 16'h1234);
    chk("m0_valid", 16'(out_valid), 16'h0001);
    chk("m0_ovf", 16'(overflow), 16'h0000);

    // Mode 1, two samples
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 2'd1, 16'h00AB);
    step(1'b1, 1'b1, 1'b1, 2'd1, 16'h00AB);
    tick_val(1'b1, 2'd1, 16'h00CD);
    chk("m1_data", out_data, 16'hCDAB);
    chk("m1_valid", 16'(out_valid), 16'h0001);

    // Mode 3, eight samples 0,1,2,3,0,1,2,3
    step(1'b0, 1'b0, 1'b1, 2'd3, 16'h0000);
    for (int i = 0; i < 8; i++) tick_val(1'b1, 2'd3, 16'(i % 4));
    chk("m3_data", out_data, 16'hE4E4);
    chk("m3_valid", 16'(out_valid), 16'h0001);

    // Mode 0 with back-pressure: second word dropped
    step(1'b0, 1'b0, 1'b1, 2'd0, 16'h1111);
    tick_val(1'b0, 2'd0, 16'h1111);
    tick_val(1'b0, 2'd0, 16'h2222);
    chk("ovf_data", out_data, 16'h1111);
    chk("ovf_flag", 16'(overflow), 16'h0001);
    step(1'b0, 1'b1, 1'b1, 2'd0, 16'h2222);
    chk("ovf_drained", 16'(out_valid), 16'h0000);
    chk("ovf_sticky", 16'(overflow), 16'h0001);
    step(1'b0, 1'b1, 1'b0, 2'd0, 16'h2222);
    chk("ovf_sticky2", 16'(overflow), 16'h0001);
    step(1'b0, 1'b0, 1'b0, 2'd1, 16'h0055);
    chk("ovf_cleared", 16'(overflow), 16'h0000);

    // Mode 1, partial word discarded by enable low
    step(1'b0, 1'b0, 1'b1, 2'd1, 16'h0055);
    tick_val(1'b1, 2'd1, 16'h0055);
    step(1'b0, 1'b0, 1'b1, 2'd1, 16'h0011);
    tick_val(1'b1, 2'd1, 16'h0011);
    tick_val(1'b1, 2'd1, 16'h0022);
    chk("discard_data", out_data, 16'h2211);
    chk("discard_valid", 16'(out_valid), 16'h0001);

    // Asynchronous reset with a pending word, mid-word
    step(1'b0, 1'b0, 1'b0, 2'd2, 16'h0009);
    tick_val(1'b0, 2'd2, 16'h0009);
    for (int i = 0; i < 4; i++) tick_val(1'b0, 2'd2, 16'h0007);
    tick_val(1'b0, 2'd2, 16'h0003);
    chk("pre_rst_valid", 16'(out_valid), 16'h0001);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 16'(out_valid), 16'h0000);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_ovf", 16'(overflow), 16'h0000);
    model_reset();
    #1 rst_n = 1'b1;

    // Mode 2 after reset
    step(1'b0, 1'b0, 1'b1, 2'd2, 16'h0001);
    tick_val(1'b1, 2'd2, 16'h0001);
    tick_val(1'b1, 2'd2, 16'h0002);
    tick_val(1'b1, 2'd2, 16'h0003);
    tick_val(1'b1, 2'd2, 16'h0004);
    chk("m2_data", out_data, 16'h4321);
    chk("m2_valid", 16'(out_valid), 16'h0001);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)),
           1'(($urandom % 12) != 0),
           1'(($urandom % 3) != 0),
           2'($urandom),
           16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
